// File: rtl/pad_cfg_pkg.sv
// Shared types and constants for the pad configuration controller.
// A config word is {pd, pu, sl, cs, ie}.
package pad_cfg_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_COMMIT = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  localparam int IE = 0;
  localparam int CS = 1;
  localparam int SL = 2;
  localparam int PU = 3;
  localparam int PD = 4;

  localparam logic [4:0] BIDIR_RST = 5'b00001;
  localparam logic [4:0] INPUT_RST = 5'b00000;

  // Enabling both pulls at once fights the pad and burns static current.
  function automatic logic legal_word(input logic [4:0] w);
    return !(w[PU] && w[PD]);
  endfunction

endpackage

// File: rtl/pad_cfg_sweep.sv
// Pad index counter with a STAGGER-cycle prescaler; strobes one pad update
// per STAGGER cycles, the first one in the cycle right after start.
module pad_cfg_sweep #(
  parameter int N       = 54,
  parameter int STAGGER = 4,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              step,
  output logic              last,
  output logic [ADDR_W-1:0] idx
);

  localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STAGGER - 1);

  logic          running;
  logic [CW-1:0] cnt;

  assign step = running && (cnt == '0);
  assign last = step && (idx == ADDR_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      idx     <= '0;
    end else if (running) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (last) begin
        running <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
        cnt <= RELOAD;
      end
    end
  end

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Pad electrical configuration: shadow store written over a command port,
// copied pad-by-pad into the active pad controls on COMMIT.
module pad_cfg_ctrl
  import pad_cfg_pkg::*;
#(
  parameter int NUM_INPUT = 12,
  parameter int NUM_BIDIR = 42,
  parameter int STAGGER   = 4,
  localparam int ADDR_W   = $clog2(NUM_BIDIR + NUM_INPUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_op,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [4:0]           cfg_wdata,
  output logic                 rsp_valid,
  output logic [4:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [NUM_BIDIR-1:0] bidir_ie,
  output logic [NUM_BIDIR-1:0] bidir_cs,
  output logic [NUM_BIDIR-1:0] bidir_sl,
  output logic [NUM_BIDIR-1:0] bidir_pu,
  output logic [NUM_BIDIR-1:0] bidir_pd,
  output logic [NUM_INPUT-1:0] input_pu,
  output logic [NUM_INPUT-1:0] input_pd
);

  localparam int N = NUM_BIDIR + NUM_INPUT;

  // state   | meaning
  // S_IDLE  | accepting commands
  // S_SWEEP | copying shadow to active, one pad per STAGGER cycles
  // S_DONE  | last pad written; respond and reopen the port
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t            state;
  logic [4:0]        sh_b [NUM_BIDIR];
  logic [PD:PU]      sh_i [NUM_INPUT];
  op_e               op;
  logic              accept, addr_ok, cmd_err, wr_en, start;
  logic [4:0]        rd_word;
  logic              step, last;
  logic [ADDR_W-1:0] idx;

  assign op      = op_e'(cfg_op);
  assign accept  = cfg_valid && cfg_ready;
  // Extra bit keeps the compare correct when N is a power of two.
  assign addr_ok = ({1'b0, cfg_addr} < (ADDR_W + 1)'(N));
  assign wr_en   = accept && (op == OP_WRITE) && !cmd_err;
  assign start   = accept && (op == OP_COMMIT);

  always_comb begin
    cmd_err = 1'b0;
    case (op)
      OP_WRITE:  cmd_err = !addr_ok || !legal_word(cfg_wdata);
      OP_READ:   cmd_err = !addr_ok;
      OP_COMMIT: cmd_err = 1'b0;
      default:   cmd_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_BIDIR; i++)
      if (cfg_addr == ADDR_W'(i)) rd_word = sh_b[i];
    for (int i = 0; i < NUM_INPUT; i++)
      if (cfg_addr == ADDR_W'(NUM_BIDIR + i)) rd_word = {sh_i[i], 3'b000};
  end

  pad_cfg_sweep #(.N(N), .STAGGER(STAGGER), .ADDR_W(ADDR_W)) u_sweep (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .step  (step),
    .last  (last),
    .idx   (idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_COMMIT) begin
              state     <= S_SWEEP;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= cmd_err;
              if (op == OP_READ && !cmd_err) rsp_rdata <= rd_word;
            end
          end
        end
        S_SWEEP: if (last) state <= S_DONE;
        S_DONE: begin
          state     <= S_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BIDIR; i++) sh_b[i] <= BIDIR_RST;
      for (int i = 0; i < NUM_INPUT; i++) sh_i[i] <= INPUT_RST[PD:PU];
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BIDIR; i++)
        if (cfg_addr == ADDR_W'(i)) sh_b[i] <= cfg_wdata;
      for (int i = 0; i < NUM_INPUT; i++)
        if (cfg_addr == ADDR_W'(NUM_BIDIR + i)) sh_i[i] <= cfg_wdata[PD:PU];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bidir_ie <= {NUM_BIDIR{BIDIR_RST[IE]}};
      bidir_cs <= {NUM_BIDIR{BIDIR_RST[CS]}};
      bidir_sl <= {NUM_BIDIR{BIDIR_RST[SL]}};
      bidir_pu <= {NUM_BIDIR{BIDIR_RST[PU]}};
      bidir_pd <= {NUM_BIDIR{BIDIR_RST[PD]}};
      input_pu <= {NUM_INPUT{INPUT_RST[PU]}};
      input_pd <= {NUM_INPUT{INPUT_RST[PD]}};
    end else if (step) begin
      for (int i = 0; i < NUM_BIDIR; i++) begin
        if (idx == ADDR_W'(i)) begin
          bidir_ie[i] <= sh_b[i][IE];
          bidir_cs[i] <= sh_b[i][CS];
          bidir_sl[i] <= sh_b[i][SL];
          bidir_pu[i] <= sh_b[i][PU];
          bidir_pd[i] <= sh_b[i][PD];
        end
      end
      for (int i = 0; i < NUM_INPUT; i++) begin
        if (idx == ADDR_W'(NUM_BIDIR + i)) begin
          input_pu[i] <= sh_i[i][PU];
          input_pd[i] <= sh_i[i][PD];
        end
      end
    end
  end

endmodule
